// File: rtl/mdu.sv
// Multiply/divide unit for the MIPS execute stage, holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run with a fixed, parameterised latency. While an operation is in
// flight, busy is high and any new start request is ignored.
// Optional build macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (ops 6-9), which
// accumulate into {hi,lo}. When the macro is not defined, those op codes are no-ops.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam logic [7:0] L_MUL_LOAD = 8'(MULT_CYCLES - 1);
   localparam logic [7:0] L_DIV_LOAD = 8'(DIV_CYCLES - 1);

   state_t        r_state, w_stateNext;
   logic [7:0]    r_cnt, w_cntNext;
   logic [31:0]   r_a, r_b, r_hi, r_lo;
   logic [3:0]    r_op;
   logic          r_done;
   logic [31:0]   w_hiNext, w_loNext;
   logic          w_doneNext, w_load;
   logic          w_startMul, w_startDiv;
   logic          w_opSigned, w_accAdd, w_accSub;
   logic signed [32:0] w_mulA, w_mulB;
   logic signed [63:0] w_mulFull;
   logic [63:0]   w_mulResult;
   logic          w_dvdNeg, w_dvsNeg;
   logic [31:0]   w_dvd, w_dvs, w_dvsSafe, w_qMag, w_rMag, w_quot, w_rem;

   // Decode the incoming request and the latched op; the latched op selects signedness and accumulate mode
   always_comb begin
      w_startMul = (mdu_op == 4'd0) || (mdu_op == 4'd1);
      w_startDiv = (mdu_op == 4'd2) || (mdu_op == 4'd3);
      w_opSigned = (r_op == 4'd0) || (r_op == 4'd2);
      w_accAdd   = 1'b0;
      w_accSub   = 1'b0;
`ifdef MDU_MADD_EN
      w_startMul = w_startMul || (mdu_op >= 4'd6 && mdu_op <= 4'd9);
      w_opSigned = w_opSigned || (r_op == 4'd6) || (r_op == 4'd8);
      w_accAdd   = (r_op == 4'd6) || (r_op == 4'd7);
      w_accSub   = (r_op == 4'd8) || (r_op == 4'd9);
`endif
   end

   // One 33x33 signed multiplier covers both signed and unsigned forms by choosing the extension bit
   always_comb begin
      w_mulA    = {w_opSigned & r_a[31], r_a};
      w_mulB    = {w_opSigned & r_b[31], r_b};
      w_mulFull = w_mulA * w_mulB;
      if (w_accAdd) begin
         w_mulResult = {r_hi, r_lo} + w_mulFull;
      end else if (w_accSub) begin
         w_mulResult = {r_hi, r_lo} - w_mulFull;
      end else begin
         w_mulResult = w_mulFull;
      end
   end

   // A single unsigned divider runs on operand magnitudes. The signs are fixed up afterwards,
   // which also handles 0x80000000 / -1 without overflow. A zero divisor is swapped for 1
   // purely so the divider sees a defined input; that result is never written.
   always_comb begin
      w_dvdNeg  = w_opSigned & r_a[31];
      w_dvsNeg  = w_opSigned & r_b[31];
      w_dvd     = w_dvdNeg ? (~r_a + 32'd1) : r_a;
      w_dvs     = w_dvsNeg ? (~r_b + 32'd1) : r_b;
      w_dvsSafe = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
      w_qMag    = w_dvd / w_dvsSafe;
      w_rMag    = w_dvd % w_dvsSafe;
      w_quot    = (w_dvdNeg ^ w_dvsNeg) ? (~w_qMag + 32'd1) : w_qMag;
      w_rem     = w_dvdNeg ? (~w_rMag + 32'd1) : w_rMag;
   end

   // Next-state, counter and HI/LO update logic; requests are only accepted while idle
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_hiNext    = r_hi;
      w_loNext    = r_lo;
      w_doneNext  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_startMul) begin
                  w_stateNext = S_MUL;
                  w_cntNext   = L_MUL_LOAD;
                  w_load      = 1'b1;
               end else if (w_startDiv) begin
                  w_stateNext = S_DIV;
                  w_cntNext   = L_DIV_LOAD;
                  w_load      = 1'b1;
               end else if (mdu_op == 4'd4) begin
                  w_hiNext = a;
               end else if (mdu_op == 4'd5) begin
                  w_loNext = a;
               end
            end
         end
         S_MUL: begin
            if (r_cnt != 8'd0) begin
               w_cntNext = r_cnt - 8'd1;
            end else begin
               w_stateNext          = S_IDLE;
               w_doneNext           = 1'b1;
               {w_hiNext, w_loNext} = w_mulResult;
            end
         end
         S_DIV: begin
            if (r_cnt != 8'd0) begin
               w_cntNext = r_cnt - 8'd1;
            end else begin
               w_stateNext = S_IDLE;
               w_doneNext  = 1'b1;
               if (r_b != 32'd0) begin
                  w_hiNext = w_rem;
                  w_loNext = w_quot;
               end
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over everything and abandons any operation in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 4'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_hi    <= w_hiNext;
         r_lo    <= w_loNext;
         r_done  <= w_doneNext;
         if (w_load) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= mdu_op;
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the MIPS datapath.
- Sits beside the ALU in the execute stage. It consumes the rs/rt operand values the datapath produces and holds the architectural HI/LO registers.
- Models multi-cycle latency with a busy flag. The CPU's hazard/stall logic uses that flag to freeze the pipeline while the unit is busy, and while a new mult/div/mthi/mtlo/mfhi/mflo arrives.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for MULT/MULTU (legal range 1..255).
- DIV_CYCLES, 10, cycles busy is held for DIV/DIVU (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk.
- start  input  1  request strobe; qualifies mdu_op for one cycle.
- mdu_op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; all other codes are no-ops.
- a  input  32  rs operand.
- b  input  32  rt operand.
- busy  output  1  high while a mult/div is in flight.
- done  output  1  one-cycle pulse on the cycle HI/LO results become visible.
- hi  output  32  architectural HI register (read by mfhi).
- lo  output  32  architectural LO register (read by mflo).

Behaviour:
- Reset: when reset=0 at a rising edge, the following outputs clear to 0 next cycle: hi, lo, busy, done, internal counter, latched operands and pending result. Reset has priority over every other input. A reset mid-operation aborts it and the result is discarded.
- States: IDLE, MUL, DIV. A 2-bit state register plus an 8-bit down-counter.
- IDLE + start + op in {0,1}:
  - latch a, b and op at edge k;
  - go to MUL; counter = MULT_CYCLES-1; busy=1 from cycle k+1.
- IDLE + start + op in {2,3}: same as above, but go to DIV with DIV_CYCLES.
- MUL/DIV, counter != 0: decrement the counter each edge.
- MUL/DIV, counter == 0, at that edge:
  - hi/lo take the result;
  - busy drops to 0 and done pulses 1 for one cycle;
  - return to IDLE.
  - Net timing: busy is high for exactly N cycles, and the result is visible in cycle k+N+1.
- MTHI/MTLO (op 4/5) in IDLE with start: hi (resp. lo) = a at that edge. No busy, done stays 0.
- start while busy=1: ignored entirely, whatever the op. No state, operand or HI/LO change. The CPU is required to stall instead.
- Unknown op with start: no-op.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64-bit product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU): the full DIV_CYCLES latency still runs, busy and done behave normally, and hi/lo stay unchanged.
- Results are computed from the latched operands. Changes on a/b after the start edge have no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - ops 6-9 run with MULT_CYCLES latency;
  - MADD: {hi,lo} += signed product. MADDU: {hi,lo} += unsigned product.
  - MSUB: {hi,lo} -= signed product. MSUBU: {hi,lo} -= unsigned product.
  - all four use 64-bit wrap-around arithmetic;
  - the accumulate uses the hi/lo value present at completion time.
- Undefined: ops 6-9 are treated as unknown, i.e. no-op with start, and no accumulate hardware is built.

Test Plan:
- Reset held low 2 cycles, then released -> hi=lo=0, busy=0, done=0. Then start MULT a=0xFFFFFFFF (-1), b=2 -> busy high exactly 5 cycles, done pulses once, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=2 -> lo=3, hi=1.
- Divide by zero: MTHI a=0x11111111 and MTLO a=0x22222222, then DIV b=0 -> busy 10 cycles, done pulses, hi=0x11111111, lo=0x22222222.
- Start MULT a=3, b=4, then at busy cycle 2:
  - MTLO a=0x55 and a second MULT are ignored;
  - final lo=12, hi=0.
- Separate run: start DIV, pull reset low at busy cycle 4 -> next cycle busy=0, hi=lo=0, and no done pulse ever appears.
- With MDU_MADD_EN: MTLO a=10, then MADD a=3, b=4 -> lo=22, hi=0. Then MSUBU a=30, b=1 -> {hi,lo}=0xFFFFFFFF_FFFFFFF8.
